// File: rtl/collision_check_seq_if.sv
// Bundle of the collision query handshake, the board read port and the
// response handshake. The checker sits on the slave side; the game control
// FSM together with the board RAM sit on the master side.
interface collision_check_seq_if #(
  parameter int COORD_W = 6,
  parameter int CELL_W  = 3,
  parameter int ADDR_W  = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic [4*COORD_W-1:0]   req_x;
  logic [4*COORD_W-1:0]   req_y;

  logic                   rd_en;
  logic [ADDR_W-1:0]      rd_addr;
  logic [CELL_W-1:0]      rd_data;

  logic                   resp_valid;
  logic                   resp_ready;
  logic                   resp_collided;
  logic [3:0]             resp_mask;
  logic                   resp_oob;

  modport slave (
    input  req_valid, req_x, req_y, rd_data, resp_ready,
    output req_ready, rd_en, rd_addr,
    output resp_valid, resp_collided, resp_mask, resp_oob
  );

  modport master (
    output req_valid, req_x, req_y, rd_data, resp_ready,
    input  req_ready, rd_en, rd_addr,
    input  resp_valid, resp_collided, resp_mask, resp_oob
  );
endinterface

// File: rtl/collision_check_seq.sv
// Sequential collision checker for a four-cell brick placement against a
// board held in a RAM with a one-cycle read latency.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a query; req_ready high
// RD    | one cell per cycle (idx 0..3); read issued for in-bounds cells
// DRAIN | no read; the last cell's RAM data is captured here
// RESP  | response presented until the consumer takes it
//
// rd_en/rd_addr are registered, so the read for a cell is prepared on the
// edge before that cell's RD cycle: cell 0 on the accepting edge, cell k+1
// on the edge leaving cell k. Out-of-bounds cells never raise rd_en, so an
// illegal address cannot reach the RAM.
module collision_check_seq #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int COORD_W = 6,
  parameter int CELL_W  = 3,
  parameter int ADDR_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  collision_check_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                 state;
  logic [1:0]             idx;
  logic [4*COORD_W-1:0]   lat_x;
  logic [4*COORD_W-1:0]   lat_y;

  // read issued in the previous cycle, and which cell it belongs to
  logic                   rd_pend;
  logic [1:0]             rd_pend_idx;

  logic                   rd_en_q;
  logic [ADDR_W-1:0]      rd_addr_q;
  logic                   resp_valid_q;
  logic                   resp_collided_q;
  logic [3:0]             resp_mask_q;
  logic                   resp_oob_q;

  logic [1:0]             nxt_idx;
  logic [COORD_W-1:0]     cur_x, cur_y;
  logic [COORD_W-1:0]     nxt_x, nxt_y;
  logic [COORD_W-1:0]     acc_x, acc_y;
  logic                   cur_in, nxt_in, acc_in;
  logic [ADDR_W-1:0]      nxt_addr, acc_addr;
  logic [3:0]             mask_nxt;

  function automatic int sext(input logic [COORD_W-1:0] v);
    logic [31:0] w;
    w = {{(32-COORD_W){v[COORD_W-1]}}, v};
    return int'(w);
  endfunction

  function automatic logic cell_in_bounds(input logic [COORD_W-1:0] x,
                                          input logic [COORD_W-1:0] y);
    int xi;
    int yi;
    xi = sext(x);
    yi = sext(y);
    return (xi >= 0) && (xi <= BOARD_W - 1) && (yi >= 0) && (yi <= BOARD_H - 1);
  endfunction

  // only meaningful for in-bounds cells, where both coordinates are non-negative
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    int xi;
    int yi;
    xi = sext(x);
    yi = sext(y);
    return ADDR_W'(yi * BOARD_W + xi);
  endfunction

  // Decode current/next/incoming cell and fold this edge's updates into the mask.
  always_comb begin
    nxt_idx  = idx + 2'd1;
    cur_x    = lat_x[idx*COORD_W +: COORD_W];
    cur_y    = lat_y[idx*COORD_W +: COORD_W];
    nxt_x    = lat_x[nxt_idx*COORD_W +: COORD_W];
    nxt_y    = lat_y[nxt_idx*COORD_W +: COORD_W];
    acc_x    = bus.req_x[COORD_W-1:0];
    acc_y    = bus.req_y[COORD_W-1:0];
    cur_in   = cell_in_bounds(cur_x, cur_y);
    nxt_in   = cell_in_bounds(nxt_x, nxt_y);
    acc_in   = cell_in_bounds(acc_x, acc_y);
    nxt_addr = cell_addr(nxt_x, nxt_y);
    acc_addr = cell_addr(acc_x, acc_y);

    mask_nxt = resp_mask_q;
    if (rd_pend && (bus.rd_data != CELL_W'(0))) begin
      mask_nxt[rd_pend_idx] = 1'b1;
    end
    if ((state == RD) && !cur_in) begin
      mask_nxt[idx] = 1'b1;
    end
  end

  // Main controller: state, cell walk, read strobe and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= 2'd0;
      lat_x           <= '0;
      lat_y           <= '0;
      rd_pend         <= 1'b0;
      rd_pend_idx     <= 2'd0;
      rd_en_q         <= 1'b0;
      rd_addr_q       <= '0;
      resp_valid_q    <= 1'b0;
      resp_collided_q <= 1'b0;
      resp_mask_q     <= 4'b0000;
      resp_oob_q      <= 1'b0;
    end else begin
      rd_pend     <= rd_en_q;
      rd_pend_idx <= idx;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_x           <= bus.req_x;
            lat_y           <= bus.req_y;
            resp_mask_q     <= 4'b0000;
            resp_oob_q      <= 1'b0;
            resp_collided_q <= 1'b0;
            idx             <= 2'd0;
            rd_en_q         <= acc_in;
            rd_addr_q       <= acc_in ? acc_addr : '0;
            state           <= RD;
          end
        end
        RD: begin
          resp_mask_q     <= mask_nxt;
          resp_collided_q <= |mask_nxt;
          if (!cur_in) begin
            resp_oob_q <= 1'b1;
          end
          idx <= nxt_idx;
          if (idx == 2'd3) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            state     <= DRAIN;
          end else begin
            rd_en_q   <= nxt_in;
            rd_addr_q <= nxt_in ? nxt_addr : '0;
          end
        end
        DRAIN: begin
          resp_mask_q     <= mask_nxt;
          resp_collided_q <= |mask_nxt;
          resp_valid_q    <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = (state == IDLE);
  assign bus.rd_en         = rd_en_q;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_collided = resp_collided_q;
  assign bus.resp_mask     = resp_mask_q;
  assign bus.resp_oob      = resp_oob_q;

endmodule
